// File: rtl/cop_ise_arb.sv
// Shares one combinational ISE datapath between two coprocessor requesters.
// Grants round-robin, holds operands through execution and holds the result until it is taken.
module cop_ise_arb #(
    parameter int EXEC_CYCLES = 1,
    parameter int XLEN        = 64
) (
    input  logic            cop_clk,
    input  logic            cop_rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_insn,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_insn,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_rd,
    output logic            rsp0_err,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_rd,
    output logic            rsp1_err,
    output logic [31:0]     ise_insn,
    output logic [XLEN-1:0] ise_rs1,
    output logic [XLEN-1:0] ise_rs2,
    input  logic            ise_sel,
    input  logic [XLEN-1:0] ise_rd,
    output logic            busy,
    output logic [31:0]     ops_done,
    output logic [15:0]     err_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    logic [1:0]      state_reg;
    logic            rr_ptr_reg;
    logic            owner_reg;
    logic [3:0]      cnt_reg;
    logic [31:0]     insn_reg;
    logic [XLEN-1:0] rs1_reg;
    logic [XLEN-1:0] rs2_reg;
    logic [XLEN-1:0] rd_reg;
    logic            err_reg;
    logic [31:0]     ops_done_reg;
    logic [15:0]     err_cnt_reg;

    logic any_valid;
    logic grant;
    logic rsp_hs;

    // With a single requester it wins outright; rr_ptr only breaks ties.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? rr_ptr_reg : ~req0_valid;
        rsp_hs    = (state_reg == RESP) && (owner_reg ? rsp1_ready : rsp0_ready);
    end

    assign req0_ready = (state_reg == IDLE) && any_valid && !grant;
    assign req1_ready = (state_reg == IDLE) && any_valid && grant;

    assign rsp0_valid = (state_reg == RESP) && !owner_reg;
    assign rsp1_valid = (state_reg == RESP) && owner_reg;
    assign rsp0_rd    = rd_reg;
    assign rsp1_rd    = rd_reg;
    assign rsp0_err   = err_reg;
    assign rsp1_err   = err_reg;

    // Operand registers only load on accept, so the datapath inputs stay frozen outside EXEC.
    assign ise_insn = insn_reg;
    assign ise_rs1  = rs1_reg;
    assign ise_rs2  = rs2_reg;

    assign busy     = (state_reg != IDLE);
    assign ops_done = ops_done_reg;
    assign err_cnt  = err_cnt_reg;

    always_ff @(posedge cop_clk or negedge cop_rst) begin
        if (!cop_rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= 1'b0;
            owner_reg    <= 1'b0;
            cnt_reg      <= '0;
            insn_reg     <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            err_reg      <= 1'b0;
            ops_done_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        owner_reg <= grant;
                        insn_reg  <= grant ? req1_insn : req0_insn;
                        rs1_reg   <= grant ? req1_rs1 : req0_rs1;
                        rs2_reg   <= grant ? req1_rs2 : req0_rs2;
                        cnt_reg   <= CNT_INIT;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        err_reg   <= ~ise_sel;
                        rd_reg    <= ise_sel ? ise_rd : '0;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        state_reg    <= IDLE;
                        rr_ptr_reg   <= ~owner_reg;
                        ops_done_reg <= ops_done_reg + 32'd1;
                        if (err_reg && err_cnt_reg != 16'hFFFF) begin
                            err_cnt_reg <= err_cnt_reg + 16'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cop_ise_arb.sv
// Randomized bench for cop_ise_arb: accepts push expected results into a scoreboard,
// a separate monitor pops and compares them when the response appears.
module tb_cop_ise_arb;

    localparam int E = 4;

    logic        cop_clk;
    logic        cop_rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_insn, req1_insn;
    logic [63:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [63:0] rsp0_rd, rsp1_rd;
    logic        rsp0_err, rsp1_err;
    logic [31:0] ise_insn;
    logic [63:0] ise_rs1, ise_rs2, ise_rd;
    logic        ise_sel;
    logic        busy;
    logic [31:0] ops_done;
    logic [15:0] err_cnt;

    cop_ise_arb #(.EXEC_CYCLES(E), .XLEN(64)) dut (
        .cop_clk(cop_clk), .cop_rst(cop_rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_insn(req0_insn),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_insn(req1_insn),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rd(rsp0_rd), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rd(rsp1_rd), .rsp1_err(rsp1_err),
        .ise_insn(ise_insn), .ise_rs1(ise_rs1), .ise_rs2(ise_rs2),
        .ise_sel(ise_sel), .ise_rd(ise_rd),
        .busy(busy), .ops_done(ops_done), .err_cnt(err_cnt)
    );

    // Datapath stub: low opcode bits 00 are "not recognised"; one fixed word returns DEADBEEF.
    function automatic logic stub_sel(input logic [31:0] i);
        return i[1:0] != 2'b00;
    endfunction
    function automatic logic [63:0] stub_rd(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        if (i == 32'h0000_0033) return 64'hDEAD_BEEF;
        return (a + {b[31:0], b[63:32]}) ^ {i, ~i};
    endfunction

    assign ise_sel = stub_sel(ise_insn);
    assign ise_rd  = stub_rd(ise_insn, ise_rs1, ise_rs2);

    typedef struct {
        bit          port;
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] rd;
        logic        err;
        time         t_acc;
    } exp_t;

    exp_t        q[$];
    bit          grants[$];
    bit          busy_m, rr_m;
    logic [31:0] ops_m;
    logic [15:0] err_m;
    bit          acc0, acc1;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial cop_clk = 1'b0;
    always #5 cop_clk = ~cop_clk;

    // Issue side: predict the grant, check ready, push the expected result on accept.
    always @(negedge cop_clk) begin : issue_side
        bit g, e0, e1;
        if (cop_rst) begin
            e0 = 0; e1 = 0; g = 0;
            if (!busy_m && (req0_valid || req1_valid)) begin
                g  = (req0_valid && req1_valid) ? rr_m : req1_valid;
                e0 = !g;
                e1 = g;
            end
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (e0 || e1) begin
                exp_t x;
                x.port  = g;
                x.insn  = g ? req1_insn : req0_insn;
                x.rs1   = g ? req1_rs1 : req0_rs1;
                x.rs2   = g ? req1_rs2 : req0_rs2;
                x.err   = !stub_sel(x.insn);
                x.rd    = x.err ? 64'd0 : stub_rd(x.insn, x.rs1, x.rs2);
                x.t_acc = $time;
                q.push_back(x);
                busy_m = 1;
            end
        end
    end

    // Response monitor: latency, operand hold, result stability, handshake and counters.
    always begin : rsp_monitor
        exp_t e;
        int   cyc;
        bit   rdy;
        @(negedge cop_clk);
        #1;
        if (cop_rst) begin
            chk("ops_done", ops_done, ops_m);
            chk("err_cnt", err_cnt, err_m);
            if (!busy_m || q.size() == 0) begin
                chk("busy_idle", busy, 0);
                chk("rsp0_valid_idle", rsp0_valid, 0);
                chk("rsp1_valid_idle", rsp1_valid, 0);
            end else begin
                e   = q[0];
                cyc = int'(($time - e.t_acc) / 10);
                chk("busy", busy, cyc >= 1);
                if (cyc >= 1 && cyc <= E) begin
                    chk("ise_insn_hold", ise_insn, e.insn);
                    chk("ise_rs1_hold", ise_rs1, e.rs1);
                    chk("ise_rs2_hold", ise_rs2, e.rs2);
                end
                if (cyc <= E) begin
                    chk("rsp0_valid_early", rsp0_valid, 0);
                    chk("rsp1_valid_early", rsp1_valid, 0);
                end else begin
                    chk("rsp0_valid", rsp0_valid, !e.port);
                    chk("rsp1_valid", rsp1_valid, e.port);
                    chk("rsp_rd", e.port ? rsp1_rd : rsp0_rd, e.rd);
                    chk("rsp_err", e.port ? rsp1_err : rsp0_err, e.err);
                    rdy = e.port ? rsp1_ready : rsp0_ready;
                    if (rdy) begin
                        void'(q.pop_front());
                        busy_m = 0;
                        rr_m   = !e.port;
                        ops_m  = ops_m + 32'd1;
                        if (e.err && err_m != 16'hFFFF) err_m = err_m + 16'd1;
                        grants.push_back(e.port);
                        $display("txn port=%0d insn=%h rd=%h err=%0d", e.port, e.insn, e.rd, e.err);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] rand_insn(input int perr);
        logic [31:0] i;
        i = $urandom;
        if ($urandom_range(99) < perr) i[1:0] = 2'b00;
        else if (i[1:0] == 2'b00)      i[1:0] = 2'b11;
        return i;
    endfunction

    // Requesters hold valid and payload until accepted, then may re-raise immediately.
    task automatic run_cycles(input int n, input int p0, input int p1, input int pr, input int perr);
        for (int k = 0; k < n; k++) begin
            @(posedge cop_clk);
            #1;
            if (req0_valid && acc0) begin req0_valid = 0; acc0 = 0; end
            if (req1_valid && acc1) begin req1_valid = 0; acc1 = 0; end
            if (!req0_valid && $urandom_range(99) < p0) begin
                req0_valid = 1; req0_insn = rand_insn(perr);
                req0_rs1 = {$urandom, $urandom}; req0_rs2 = {$urandom, $urandom};
            end
            if (!req1_valid && $urandom_range(99) < p1) begin
                req1_valid = 1; req1_insn = rand_insn(perr);
                req1_rs1 = {$urandom, $urandom}; req1_rs2 = {$urandom, $urandom};
            end
            rsp0_ready = ($urandom_range(99) < pr);
            rsp1_ready = ($urandom_range(99) < pr);
        end
    endtask

    task automatic do_reset(input int cycles);
        cop_rst = 0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        acc0 = 0; acc1 = 0; busy_m = 0; rr_m = 0; ops_m = 0; err_m = 0;
        q.delete();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_rd", rsp0_rd, 0);
        chk("rst_ise_insn", ise_insn, 0);
        chk("rst_ise_rs1", ise_rs1, 0);
        chk("rst_ise_rs2", ise_rs2, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_err_cnt", err_cnt, 0);
        repeat (cycles) @(posedge cop_clk);
        #1;
        cop_rst = 1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int start;
        cop_rst = 1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_insn = 0; req1_insn = 0;
        req0_rs1 = 0; req0_rs2 = 0; req1_rs1 = 0; req1_rs2 = 0;
        busy_m = 0; rr_m = 0; ops_m = 0; err_m = 0;
        #2;
        do_reset(2);

        // Directed single request from port 0.
        req0_valid = 1; req0_insn = 32'h0000_0033; req0_rs1 = 64'h1; req0_rs2 = 64'h2;
        run_cycles(E + 3, 0, 0, 0, 0);
        chk("dir_rsp0_valid", rsp0_valid, 1);
        chk("dir_rsp0_rd", rsp0_rd, 64'hDEAD_BEEF);
        chk("dir_rsp0_err", rsp0_err, 0);
        run_cycles(2, 0, 0, 100, 0);
        chk("dir_ops_done", ops_done, 32'd1);

        // Both ports continuously requesting: grants must alternate.
        start = grants.size();
        run_cycles(50, 100, 100, 100, 0);
        run_cycles(15, 0, 0, 100, 0);
        chk("alt_count_ge4", (grants.size() - start) >= 4, 1);
        for (int i = start + 1; i < grants.size(); i++) chk("grant_alt", grants[i], !grants[i - 1]);

        // Long response stall with port 1 waiting.
        req0_valid = 1; req0_insn = rand_insn(0);
        req0_rs1 = {$urandom, $urandom}; req0_rs2 = {$urandom, $urandom};
        run_cycles(1, 0, 0, 0, 0);
        req1_valid = 1; req1_insn = rand_insn(0);
        req1_rs1 = {$urandom, $urandom}; req1_rs2 = {$urandom, $urandom};
        run_cycles(E + 11, 0, 0, 0, 0);
        run_cycles(E + 6, 0, 0, 100, 0);

        // Error saturation, starting just below the ceiling.
        force dut.err_cnt_reg = 16'hFFFD;
        err_m = 16'hFFFD;
        #1;
        release dut.err_cnt_reg;
        run_cycles(60, 60, 60, 70, 100);
        run_cycles(15, 0, 0, 100, 0);
        chk("err_cnt_sat", err_cnt, 16'hFFFF);

        // Random mix with stalls and errors.
        run_cycles(300, 50, 50, 25, 30);
        run_cycles(20, 0, 0, 100, 0);

        // Reset in the middle of EXEC discards the operation.
        req0_valid = 1; req0_insn = rand_insn(0);
        req0_rs1 = {$urandom, $urandom}; req0_rs2 = {$urandom, $urandom};
        run_cycles(3, 0, 0, 100, 0);
        do_reset(2);
        req1_valid = 1; req1_insn = rand_insn(0);
        req1_rs1 = {$urandom, $urandom}; req1_rs2 = {$urandom, $urandom};
        run_cycles(E + 6, 0, 0, 100, 0);
        chk("post_rst_ops", ops_done, 32'd1);

        // Completed-operation counter wraps.
        force dut.ops_done_reg = 32'hFFFF_FFFF;
        ops_m = 32'hFFFF_FFFF;
        #1;
        release dut.ops_done_reg;
        req0_valid = 1; req0_insn = rand_insn(0);
        req0_rs1 = {$urandom, $urandom}; req0_rs2 = {$urandom, $urandom};
        run_cycles(E + 6, 0, 0, 100, 0);
        chk("ops_wrap", ops_done, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
